// File: rtl/fp_pkg.sv
// Shared definitions for the Nroot Taylor mantissa datapath.
//   state_t     : sequencer state encoding for mant_seq_mul
//   MANT_WIDTH  : default mantissa width, hidden bit included (single precision)
package fp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MANT_WIDTH = 24;

endpackage

// File: rtl/rca_nbit.sv
// Combinational WIDTH-bit ripple-carry adder built from half-adder cells.
// Bit 0 is a lone half adder because there is no carry-in. Every higher bit is
// a full adder made of two half adders whose carries are ORed.
//   x, y  : addends
//   sum   : WIDTH-bit sum
//   cout  : carry out of the top bit
module rca_nbit #(
    parameter int WIDTH = 24
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] carry;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i == 0) begin : g_ha
            assign sum[i]   = x[i] ^ y[i];
            assign carry[i] = x[i] & y[i];
        end else begin : g_fa
            logic p;
            logic g1;
            logic g2;
            // first half adder: operand bits
            assign p  = x[i] ^ y[i];
            assign g1 = x[i] & y[i];
            // second half adder: partial sum plus incoming carry
            assign sum[i]   = p ^ carry[i-1];
            assign g2       = p & carry[i-1];
            assign carry[i] = g1 | g2;
        end
    end

    assign cout = carry[WIDTH-1];

endmodule

// File: rtl/mant_seq_mul.sv
// Sequential shift-and-add unsigned mantissa multiplier.
// One WIDTH-bit ripple addition per cycle; fixed latency of WIDTH cycles from
// the accepted start edge to the done pulse, one operation in flight.
//   clk      : rising-edge clock
//   rst_n    : synchronous active-low reset
//   start    : request, only honoured in IDLE or DONE
//   a, b     : multiplicand / multiplier, captured on the accepted start
//   busy     : operation in progress
//   done     : one-cycle pulse, product valid from this cycle
//   product  : full 2*WIDTH-bit product, held until the next completion
module mant_seq_mul
    import fp_pkg::*;
#(
    parameter int WIDTH = MANT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mplier;

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum_lo;
    logic             sum_co;
    logic [WIDTH:0]   sum;

    always_comb begin
        addend = mplier[0] ? mcand : '0;
    end

    rca_nbit #(.WIDTH(WIDTH)) u_rca (
        .x    (acc),
        .y    (addend),
        .sum  (sum_lo),
        .cout (sum_co)
    );

    assign sum = {sum_co, sum_lo};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand  <= a;
                        acc    <= '0;
                        mplier <= b;
                        cnt    <= CW'(WIDTH - 1);
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    // Right shift of {carry, acc, mplier}: the sum's LSB drops
                    // into the top of the multiplier register as it retires.
                    acc    <= sum[WIDTH:1];
                    mplier <= {sum[0], mplier[WIDTH-1:1]};
                    if (cnt == '0) begin
                        product <= {sum, mplier[WIDTH-1:1]};
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mant_seq_mul.sv
module tb_mant_seq_mul;

    localparam int W = 24;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int n_assert;
    int n_fail;
    int cyc;

    mant_seq_mul #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for done; cyc counts edges since the accepting edge.
    task automatic wait_done(input int limit);
        while (done !== 1'b1 && cyc < limit) begin
            tick();
            cyc++;
        end
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [2*W-1:0] exp);
        a     = av;
        b     = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = '1;
        b     = '1;
        cyc   = 0;
        check({tag, "_busy_e0"}, 48'(busy), 48'd1);
        wait_done(40);
        check({tag, "_latency"}, 48'(cyc), 48'd24);
        check({tag, "_product"}, product, exp);
        check({tag, "_busy_at_done"}, 48'(busy), 48'd0);
        tick();
        check({tag, "_done_width"}, 48'(done), 48'd0);
        check({tag, "_product_hold"}, product, exp);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        tick();
        tick();
        check("rst_busy", 48'(busy), 48'd0);
        check("rst_done", 48'(done), 48'd0);
        check("rst_product", product, 48'd0);
        rst_n = 1'b1;
        tick();

        do_op("half_sq", 24'h800000, 24'h800000, 48'h400000000000);
        do_op("max_sq",  24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001);
        do_op("zero_b",  24'hC00000, 24'h000000, 48'h000000000000);

        // starts during RUN are ignored
        a     = 24'hA00000;
        b     = 24'hC00000;
        start = 1'b1;
        tick();
        a = 24'hFFFFFF;
        b = 24'hFFFFFF;
        for (int i = 1; i <= 24; i++) begin
            start = (i == 5 || i == 12);
            tick();
            if (i == 23) check("ign_no_early_done", 48'(done), 48'd0);
        end
        start = 1'b0;
        check("ign_done_at_24", 48'(done), 48'd1);
        check("ign_product", product, 48'h780000000000);
        tick();

        // reset in the middle of an operation
        a     = 24'hFFFFFF;
        b     = 24'hFFFFFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_busy", 48'(busy), 48'd0);
        check("midrst_done", 48'(done), 48'd0);
        check("midrst_product", product, 48'd0);
        tick();
        check("midrst_stays_idle", 48'(busy), 48'd0);
        do_op("after_rst", 24'h900000, 24'h800000, 48'h480000000000);

        // back-to-back with start held high
        a     = 24'h800001;
        b     = 24'h000003;
        start = 1'b1;
        tick();
        cyc = 0;
        a   = 24'h123456;
        b   = 24'h000010;
        wait_done(40);
        check("b2b_first_cycle", 48'(cyc), 48'd24);
        check("b2b_first_product", product, 48'h000001800003);
        tick();
        cyc++;
        a = 24'hFFFFFF;
        b = 24'hFFFFFF;
        check("b2b_rerun_busy", 48'(busy), 48'd1);
        check("b2b_first_hold", product, 48'h000001800003);
        wait_done(80);
        check("b2b_second_cycle", 48'(cyc), 48'd49);
        check("b2b_second_product", product, 48'h000001234560);
        start = 1'b0;
        tick();
        check("b2b_end_idle", 48'(busy), 48'd0);
        check("b2b_end_done", 48'(done), 48'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mant_seq_mul.md
# mant_seq_mul

Multi-cycle shift-and-add unsigned multiplier for the Nroot Taylor datapath. It forms the full-width product of two normalised mantissas (hidden bit included) with one WIDTH-bit ripple-carry addition per cycle. It feeds the Taylor-term accumulation stage, which consumes `product` on the `done` pulse. Fixed latency, one operation in flight, start/done handshake.

## Interface
- `WIDTH`, default 24: mantissa width including hidden bit (24 = single precision).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; synchronous and active-low.
- `start`  in  1  request; sampled only when not busy.
- `a`  in  WIDTH  multiplicand, captured on an accepted start.
- `b`  in  WIDTH  multiplier, captured on an accepted start.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse; `product` is valid from this cycle.
- `product`  out  2*WIDTH  unsigned a*b; holds until the next completion.

## Operation
- States:
  - IDLE: `busy`=0, `done`=0.
  - RUN: `busy`=1.
  - DONE: `done`=1, `busy`=0.
- Accepted start: `start`=1 at a rising edge while in IDLE or DONE. On it:
  - mcand←a, acc←0, mplier←b, cnt←WIDTH−1; state→RUN.
- `start` while in RUN is ignored. No queueing, no error flag.
- RUN step, each edge:
  - sum[WIDTH:0] = acc + (mplier[0] ? mcand : 0), via the rca sub-module; carry-out is sum[WIDTH].
  - {acc, mplier} ← {sum, mplier[WIDTH-1:1]}, i.e. a right shift of the (2*WIDTH+1)-bit concatenation.
  - If cnt=0: `product`←{sum, mplier[WIDTH-1:1]} (same value as the shifted register) and state→DONE. Otherwise cnt←cnt−1.
- DONE lasts exactly one cycle. It goes to RUN if `start`=1 (back-to-back), else to IDLE.
- No overflow is possible: the product always fits in 2*WIDTH bits. No rounding or normalisation here; the downstream stage does both.
- Operands of 0 do not shorten latency. Latency is fixed regardless of data.
- Reset (`rst_n`=0 at an edge) overrides everything, including mid-RUN. It sets:
  - state=IDLE, `busy`=0, `done`=0, `product`=0, cnt=0, acc=0, mcand=0, mplier=0.
- The partial result is discarded on reset. The first start after reset release behaves normally.

## Timing
- Edge E0 accepts start. `busy`=1 from E0.
- RUN edges are E1..E_WIDTH.
- After E_WIDTH: `done`=1 and `busy`=0 for one cycle, and `product` is valid.
- Latency start-edge → done-cycle: WIDTH cycles (24 by default).
- Throughput: one result per WIDTH+1 cycles with back-to-back starts (start asserted in the DONE cycle).
- `product` changes only at the edge entering DONE. It is stable in all other cycles.
- `a`/`b` may change freely after E0.
- Critical path: one WIDTH-bit ripple carry plus the shift mux.

## Structure
- Shared package `fp_pkg`:
  - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - default mantissa width constant 24.
- One sub-module, `rca_nbit` (parameter WIDTH), combinational:
  - bit 0 is an HA cell (no carry-in);
  - bits 1..WIDTH−1 are full-adder cells built from two HA cells plus an OR;
  - outputs WIDTH-bit sum and cout.
- The top level holds the FSM, counter, operand/accumulator registers and the product register.

## Test plan
- a=0x800000, b=0x800000, start one cycle → after 24 cycles `done`=1, `product`=0x400000000000, `busy` falls that cycle.
- a=0xFFFFFF, b=0xFFFFFF → `product`=0xFFFFFE000001, exercising the carry-out into acc[WIDTH].
- a=0xC00000, b=0x000000 → `product`=0 after the full 24 cycles. `done` is exactly one cycle wide.
- Start a=0xA00000, b=0xC00000; pulse `start` again at cycles 5 and 12 with a=b=0xFFFFFF → those starts are ignored; result is 0x780000000000 at cycle 24.
- Start an operation, drive `rst_n`=0 for one edge at cycle 10 → `busy`=0, `done`=0, `product`=0 next cycle. A new start a=0x900000, b=0x800000 yields 0x480000000000 24 cycles later.
- Back-to-back: `start` held high with a/b changing at each accepted edge → `done` at cycles 24 and 49, and each product matches the operands captured at its own start edge.
